piso_serializer_handshake: RTL and testbench
============================================

Name: piso_serializer_handshake

Overview:
- Upstream feeder for the 8-bit serial-in/parallel-out shift register. It accepts parallel words over a valid/ready handshake and emits them one bit per clock on SO.
- It also drives the downstream LEFT_RIGHT select with the bit order used, so the downstream PO rebuilds the original word exactly WIDTH clocks after the first bit.
- Back-to-back words stream with no bubble cycles.

Parameters:
- WIDTH, 8, word width in bits; must be ≥2 and must match the downstream register width.
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- C  input  1  clock; all state updates on posedge C.
- CLR  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  parallel word to serialize.
- DIN_VALID  input  1  DIN holds a word.
- DIN_READY  output  1  block can accept DIN this cycle.
- DIR  input  1  bit order: 0 = MSB first (downstream left shift), 1 = LSB first (downstream right shift). Sampled only at load.
- SO  output  1  serial data; connects to downstream SI.
- SO_DIR  output  1  latched DIR of the word in flight; connects to downstream LEFT_RIGHT.
- SO_VALID  output  1  SO carries a data bit this cycle.
- LAST  output  1  SO carries the final bit of the word.
- BUSY  output  1  a word is in flight.

Behaviour:
- States: IDLE and SHIFT. Internal registers: shift register sreg[WIDTH-1:0], counter bcnt[CNT_W-1:0], latched direction dir_q.
- Reset (CLR=1, asynchronous):
  - state=IDLE; sreg, bcnt and dir_q = 0.
  - SO=0, SO_DIR=0, SO_VALID=0, LAST=0, BUSY=0.
  - DIN_READY forced 0 while CLR is high.
- DIN_READY (combinational) = !CLR && (state==IDLE || (state==SHIFT && bcnt==WIDTH-1)).
- Load condition: DIN_VALID && DIN_READY at a posedge. At that edge:
  - sreg<=DIN, dir_q<=DIR, bcnt<=0, state<=SHIFT.
- Output mapping:
  - SO = dir_q ? sreg[bcnt] : sreg[WIDTH-1-bcnt].
  - SO_DIR = dir_q.
  - SO_VALID = BUSY = (state==SHIFT).
  - LAST = (state==SHIFT && bcnt==WIDTH-1).
  - SO may be implemented as a registered shift-out instead, provided the cycle timing below is identical.
- Latency: first bit appears on SO in the cycle after the load edge. The word occupies exactly WIDTH consecutive cycles.
- SHIFT state, each edge:
  - If bcnt<WIDTH-1: bcnt<=bcnt+1.
  - If bcnt==WIDTH-1 and a load occurs: reload as above. No gap cycle; SO_VALID stays 1.
  - If bcnt==WIDTH-1 and no load: state<=IDLE, bcnt<=0.
- IDLE state: SO=0, SO_VALID=0, LAST=0.
- DIR and DIN changes mid-word have no effect. Only the load edge samples them.
- DIN_VALID low in IDLE: the block stays in IDLE indefinitely.
- CLR mid-word: the word is dropped immediately. Nothing resumes after CLR deasserts; the block waits in IDLE for a new load.
- No overflow condition exists: the source holds DIN/DIN_VALID until DIN_READY is seen.

Decomposition:
- Shared package constants:
  - ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1. These are the same encoding the downstream LEFT_RIGHT uses.
- One sub-module is natural: piso_bit_counter. It is a modulo-WIDTH counter with clear and enable, and outputs its count and a terminal-count flag (bcnt==WIDTH-1).
- The FSM and mux stay in the top module.

Test Plan:
- Reset check: CLR pulse mid-run -> all outputs 0 asynchronously, DIN_READY=0 while CLR=1, then DIN_READY=1 in the first cycle after release.
- Single word, MSB first: DIN=8'hA5, DIR=0, one valid cycle -> SO sequence 1,0,1,0,0,1,0,1 on cycles 1–8; LAST only on cycle 8; SO_DIR=0. The downstream register with LEFT_RIGHT=SO_DIR shows PO=8'hA5 after cycle 8.
- Single word, LSB first: DIN=8'h3C, DIR=1 -> SO sequence 0,0,1,1,1,1,0,0; SO_DIR=1. The downstream PO (right shift) shows 8'h3C.
- Back-to-back streaming: words 8'hFF then 8'h01, DIN_VALID held high -> DIN_READY high only in the LAST cycle; 16 contiguous SO_VALID cycles; second word starts the cycle after the first word's LAST.
- Mid-word input changes: toggle DIR and change DIN to 8'h00 during word 8'hC3 -> serialized bits remain those of 8'hC3 in the original order.
- Idle gap and mid-word reset: DIN_VALID low for 5 cycles after a word -> SO_VALID=0, SO=0. Then assert CLR at bit 4 of a word -> outputs clear at once, and no bits of that word appear after CLR deasserts.

Source files
------------

// File: rtl/piso_serializer_handshake_pkg.sv
// Shared encodings for the handshake serializer and its downstream SIPO link.
package piso_serializer_handshake_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal-count flag.
module piso_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer_handshake.sv
// Parallel-in/serial-out feeder with valid/ready input and bubble-free word streaming.
module piso_serializer_handshake
  import piso_serializer_handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic             DIR,
  output logic             SO,
  output logic             SO_DIR,
  output logic             SO_VALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             dir_q;
  logic             dir_d;
  logic [CNT_W-1:0] bcnt;
  logic             bcnt_tc;
  logic             load;
  logic             shifting;
  logic [CNT_W-1:0] bit_idx;

  assign shifting  = (state_q == ST_SHIFT);
  assign DIN_READY = !CLR && ((state_q == ST_IDLE) || (shifting && bcnt_tc));
  assign load      = DIN_VALID && DIN_READY;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk (C),
    .rst (CLR),
    .clr (load),
    .en  (shifting),
    .cnt (bcnt),
    .tc  (bcnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    if (load) begin
      state_d = ST_SHIFT;
      sreg_d  = DIN;
      dir_d   = DIR;
    end else if (shifting && bcnt_tc) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  end

  assign bit_idx  = (dir_q == DIR_LSB_FIRST) ? bcnt : CNT_MAX - bcnt;
  assign SO       = shifting && sreg_q[bit_idx];
  assign SO_DIR   = dir_q;
  assign SO_VALID = shifting;
  assign BUSY     = shifting;
  assign LAST     = shifting && bcnt_tc;

endmodule

// File: tb/tb_piso_serializer_handshake.sv
// Bench for piso_serializer_handshake: table vectors, corner sequences and random streaming vs a bit-queue model.
module tb_piso_serializer_handshake;

  logic       C = 1'b0;
  logic       CLR;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic       DIR;
  logic       SO;
  logic       SO_DIR;
  logic       SO_VALID;
  logic       LAST;
  logic       BUSY;

  piso_serializer_handshake #(
    .WIDTH (8)
  ) dut (
    .C         (C),
    .CLR       (CLR),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .DIR       (DIR),
    .SO        (SO),
    .SO_DIR    (SO_DIR),
    .SO_VALID  (SO_VALID),
    .LAST      (LAST),
    .BUSY      (BUSY)
  );

  always #5 C = ~C;

  // Downstream SIPO register fed by SO with LEFT_RIGHT = SO_DIR.
  logic [7:0] po = '0;
  always @(posedge C) begin
    if (SO_VALID) po <= SO_DIR ? {SO, po[7:1]} : {po[6:0], SO};
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       so;
    logic       dir;
    logic       last;
    logic [7:0] word;
  } bit_t;
  bit_t mq[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       dr;
    logic       rdy;
    logic       so;
    logic       vld;
    logic       last;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    bit_t e;
    e = '{so: 1'b0, dir: 1'b0, last: 1'b0, word: 8'h00};
    if (mq.size() != 0) e = mq[0];
    check("SO", 32'(SO), 32'(e.so));
    check("SO_VALID", 32'(SO_VALID), 32'(mq.size() != 0));
    check("BUSY", 32'(BUSY), 32'(mq.size() != 0));
    check("LAST", 32'(LAST), 32'(e.last));
    check("SO_DIR", 32'(SO_DIR), 32'(e.dir));
  endtask

  // One cycle against the model: drive, check ready, clock, check outputs.
  task automatic drive(input logic v, input logic [7:0] d, input logic dr, output logic ld);
    bit_t popped;
    logic had;
    logic exp_rdy;
    DIN_VALID = v;
    DIN = d;
    DIR = dr;
    #1;
    exp_rdy = !CLR && (mq.size() <= 1);
    check("DIN_READY", 32'(DIN_READY), 32'(exp_rdy));
    ld = v && exp_rdy;
    @(posedge C);
    had = (mq.size() != 0);
    if (had) popped = mq.pop_front();
    if (ld) begin
      for (int i = 0; i < 8; i++) begin
        mq.push_back('{so: (dr ? d[i] : d[7 - i]), dir: dr, last: (i == 7), word: d});
      end
    end
    #1;
    check_outs();
    if (had && popped.last) check("PO", 32'(po), 32'(popped.word));
  endtask

  task automatic add_vec(input logic v, input logic [7:0] d, input logic dr,
                         input logic rdy, input logic so, input logic vld, input logic last);
    vt.push_back('{v: v, d: d, dr: dr, rdy: rdy, so: so, vld: vld, last: last});
  endtask

  initial begin
    logic ld;
    logic [7:0] words [2];
    int idx;
    int run;
    int best;
    logic pend;
    logic [7:0] pw;
    logic pdir;
    logic [7:0] a5_bits;
    logic [7:0] c3_bits;

    a5_bits = 8'b1010_0101;
    c3_bits = 8'b0011_1100;
    // Vector table: inputs for the cycle, ready before the edge, outputs after it.
    add_vec(1'b1, 8'hA5, 1'b0, 1'b1, a5_bits[7], 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) add_vec(1'b0, 8'h00, 1'b1, 1'b0, a5_bits[7 - k], 1'b1, k == 7);
    add_vec(1'b1, 8'h3C, 1'b1, 1'b1, c3_bits[0], 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) add_vec(1'b0, 8'hFF, 1'b0, 1'b0, c3_bits[k], 1'b1, k == 7);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    CLR = 1'b1;
    DIN_VALID = 1'b0;
    DIN = '0;
    DIR = 1'b0;
    #1;
    check("RST_READY", 32'(DIN_READY), 32'd0);
    check_outs();
    @(posedge C);
    @(posedge C);
    #1;
    CLR = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      DIN_VALID = vt[i].v;
      DIN = vt[i].d;
      DIR = vt[i].dr;
      #1;
      check($sformatf("TBL_READY[%0d]", i), 32'(DIN_READY), 32'(vt[i].rdy));
      @(posedge C);
      #1;
      check($sformatf("TBL_SO[%0d]", i), 32'(SO), 32'(vt[i].so));
      check($sformatf("TBL_VALID[%0d]", i), 32'(SO_VALID), 32'(vt[i].vld));
      check($sformatf("TBL_LAST[%0d]", i), 32'(LAST), 32'(vt[i].last));
      if (vt[i].vld) check($sformatf("TBL_DIR[%0d]", i), 32'(SO_DIR), 32'(i >= 8));
      if (i == 8) check("TBL_PO_A5", 32'(po), 32'h0A5);
      if (i == 16) check("TBL_PO_3C", 32'(po), 32'h03C);
    end

    // Back-to-back FF then 01 with DIN_VALID held until accepted.
    words[0] = 8'hFF;
    words[1] = 8'h01;
    idx = 0;
    run = 0;
    best = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 2) drive(1'b1, words[idx], 1'b0, ld);
      else drive(1'b0, 8'h00, 1'b0, ld);
      if (ld) idx++;
      if (SO_VALID) run++;
      else run = 0;
      if (run > best) best = run;
    end
    check("B2B_ACCEPTED", 32'(idx), 32'd2);
    check("B2B_RUN", 32'(best), 32'd16);

    // Mid-word DIN/DIR changes must not disturb the word in flight.
    drive(1'b1, 8'hC3, 1'b0, ld);
    for (int k = 0; k < 8; k++) drive(1'b0, 8'h00, k[0], ld);

    // Idle gap.
    for (int k = 0; k < 5; k++) drive(1'b0, 8'h5A, 1'b1, ld);

    // CLR at bit 4 of a word.
    drive(1'b1, 8'h96, 1'b1, ld);
    for (int k = 0; k < 4; k++) drive(1'b1, 8'h0F, 1'b0, ld);
    check("PRE_CLR_BUSY", 32'(BUSY), 32'd1);
    #1;
    CLR = 1'b1;
    mq.delete();
    #1;
    check("CLR_READY", 32'(DIN_READY), 32'd0);
    check_outs();
    @(posedge C);
    #1;
    check("CLR_HOLD_READY", 32'(DIN_READY), 32'd0);
    check_outs();
    CLR = 1'b0;
    for (int k = 0; k < 10; k++) drive(1'b0, 8'h96, 1'b1, ld);

    // Random streaming; the source holds each word until it is accepted.
    pend = 1'b0;
    pw = '0;
    pdir = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1;
        pw = 8'($urandom);
        pdir = 1'($urandom);
      end
      if (pend) drive(1'b1, pw, pdir, ld);
      else drive(1'b0, 8'($urandom), 1'($urandom), ld);
      if (ld) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
